msrv32_pc_reg_block: RTL and testbench

Program-counter register stage of the msrv32 RV32I core. Once per clock it captures the next-PC value chosen by the upstream PC multiplexer and presents it as the current PC. The fetch and immediate/branch logic read the current PC from this block. It has no enable or stall input: the PC updates on every clock edge outside reset.

---
 rtl/msrv32_pc_reg_block.sv | 26 ++
 tb/tb_msrv32_pc_reg_block.sv | 139 +++++++++++++
 2 files changed

// File: rtl/msrv32_pc_reg_block.sv
// Program-counter register stage of the msrv32 RV32I core.
// Captures the next-PC from the PC mux on every rising clock edge and presents it as the current PC.
module msrv32_pc_reg_block #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          PC_WIDTH     = 32
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_in,
    input  logic [PC_WIDTH-1:0] pc_mux_in,
    output logic [PC_WIDTH-1:0] pc_out
);

    logic [PC_WIDTH-1:0] pc_q;

    // PC register: asynchronous reset to the boot address, otherwise loads the mux value every edge
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            pc_q <= BOOT_ADDRESS[PC_WIDTH-1:0];
        end else begin
            pc_q <= pc_mux_in;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_msrv32_pc_reg_block.sv
// Directed self-checking bench for msrv32_pc_reg_block.
// Two instances share stimulus: one with the default boot address, one with 32'h0000_1000.
module tb_msrv32_pc_reg_block;

    logic        clk;
    logic        rst;
    logic [31:0] pc_mux_in;
    logic [31:0] pc_out_a;
    logic [31:0] pc_out_b;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BOOT_A = 32'h0000_0000;
    localparam logic [31:0] BOOT_B = 32'h0000_1000;

    msrv32_pc_reg_block #(.BOOT_ADDRESS(BOOT_A), .PC_WIDTH(32)) dut_a (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .pc_mux_in            (pc_mux_in),
        .pc_out               (pc_out_a)
    );

    msrv32_pc_reg_block #(.BOOT_ADDRESS(BOOT_B), .PC_WIDTH(32)) dut_b (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .pc_mux_in            (pc_mux_in),
        .pc_out               (pc_out_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one rising edge with clk starting low; returns 1 time unit after the edge, clk high
    task automatic rise();
        #5 clk = 1'b1;
        #1;
    endtask

    // Complete the cycle from just after a rising edge back to clk low
    task automatic fall();
        #4 clk = 1'b0;
        #1;
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b0;
        pc_mux_in = 32'h1234_5678;

        // 1: reset applies without a clock, and holds through clock edges
        #1 rst = 1'b1;
        #1;
        check("reset_noclk_a", pc_out_a, BOOT_A);
        check("reset_noclk_b", pc_out_b, BOOT_B);
        rise();
        check("reset_clk_a", pc_out_a, BOOT_A);
        check("reset_clk_b", pc_out_b, BOOT_B);
        fall();

        // unknown next-PC during reset must not reach the output
        pc_mux_in = 32'hxxxx_xxxx;
        rise();
        check("reset_x_a", pc_out_a, BOOT_A);
        check("reset_x_b", pc_out_b, BOOT_B);
        fall();

        // 2: release with clk low; boot address held until the first edge
        pc_mux_in = 32'h1234_5678;
        rst = 1'b0;
        #2;
        check("release_hold_a", pc_out_a, BOOT_A);
        check("release_hold_b", pc_out_b, BOOT_B);
        rise();
        check("first_edge_a", pc_out_a, 32'h1234_5678);
        check("first_edge_b", pc_out_b, 32'h1234_5678);
        fall();
        check("falling_edge", pc_out_a, 32'h1234_5678);

        // 3: one-cycle latency for a sequence
        pc_mux_in = 32'h0000_0004; rise(); check("seq_0004", pc_out_a, 32'h0000_0004); fall();
        pc_mux_in = 32'h0000_0008; rise(); check("seq_0008", pc_out_a, 32'h0000_0008); fall();
        pc_mux_in = 32'h0000_0100; rise(); check("seq_0100", pc_out_b, 32'h0000_0100); fall();
        pc_mux_in = 32'hFFFF_FFFF; rise(); check("seq_ffff", pc_out_a, 32'hFFFF_FFFF); fall();
        pc_mux_in = 32'h0000_0000; rise(); check("seq_zero", pc_out_b, 32'h0000_0000); fall();
        pc_mux_in = 32'hFFFF_FFFC; rise(); check("seq_fffc", pc_out_a, 32'hFFFF_FFFC);

        // 4: glitch on next-PC between edges is not visible
        pc_mux_in = 32'hDEAD_BEEF;
        #1;
        check("glitch_high", pc_out_a, 32'hFFFF_FFFC);
        fall();
        check("glitch_low", pc_out_a, 32'hFFFF_FFFC);
        pc_mux_in = 32'h0000_0010;
        rise();
        check("glitch_edge", pc_out_a, 32'h0000_0010);
        fall();

        // 5: mid-operation reset pulse between edges
        pc_mux_in = 32'hFFFF_FFFC;
        rise();
        check("pre_pulse", pc_out_b, 32'hFFFF_FFFC);
        fall();
        #2 rst = 1'b1;
        #1;
        check("pulse_a", pc_out_a, BOOT_A);
        check("pulse_b", pc_out_b, BOOT_B);
        #1 rst = 1'b0;
        pc_mux_in = 32'h0000_0020;
        #1;
        check("post_pulse_hold", pc_out_b, BOOT_B);
        rise();
        check("post_pulse_edge", pc_out_a, 32'h0000_0020);
        fall();

        // 6: reset coinciding with a rising edge wins
        pc_mux_in = 32'hAAAA_5555;
        #5;
        rst = 1'b1;
        clk = 1'b1;
        #1;
        check("coincide_a", pc_out_a, BOOT_A);
        check("coincide_b", pc_out_b, BOOT_B);
        #4 clk = 1'b0;
        #2 rst = 1'b0;
        rise();
        check("after_coincide", pc_out_b, 32'hAAAA_5555);
        fall();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
